rs_dispatch_scheduler: RTL

Controller for the four-entry reservation station bank. It picks a free station for each issued instruction and drives the station-select code and the issue stall. It also picks the oldest station whose operands are ready and presents it to the single execute functional unit over a valid/ready handshake. On each accepted dispatch it pulses the consumed line that frees that station. It sits between issue/decode, the reservation station bank and the execute stage.

---
 rtl/structs_pkg.sv | 21 ++
 rtl/rs_dispatch_scheduler_if.sv | 26 ++
 rtl/rs_age_matrix.sv | 33 +++
 rtl/rs_dispatch_scheduler.sv | 81 ++++++++
 4 files changed

// File: rtl/structs_pkg.sv
// Shared types and constants for the reservation-station dispatch scheduler.
package structs_pkg;
  localparam int         N_RS    = 4;
  localparam logic [2:0] RS_NONE = 3'b100;

  typedef logic [N_RS-1:0] rs_onehot_t;
  typedef logic [1:0]      rs_idx_t;

  typedef enum logic {DISP_EMPTY, DISP_HOLD} disp_state_e;

  function automatic rs_idx_t lowest_idx(rs_onehot_t m);
    rs_idx_t r = '0;
    for (int i = N_RS - 1; i >= 0; i--)
      if (m[i]) r = rs_idx_t'(i);
    return r;
  endfunction

  function automatic rs_onehot_t idx2oh(rs_idx_t i);
    return rs_onehot_t'(1) << i;
  endfunction
endpackage

// File: rtl/rs_dispatch_scheduler_if.sv
// Issue / RS-bank / execute handshake bundle for the dispatch scheduler.
interface rs_dispatch_scheduler_if;
  import structs_pkg::*;

  logic       mispredicted;
  logic       issue_valid;
  logic       issue_hold;
  rs_onehot_t busy_bus;
  rs_onehot_t ready_bus;
  logic       fu_ready;
  logic [2:0] rs_dest;
  logic       alloc_stall;
  logic       dispatch_valid;
  rs_idx_t    dispatch_sel;
  rs_onehot_t consumed_bus;

  modport master (
    output mispredicted, issue_valid, issue_hold, busy_bus, ready_bus, fu_ready,
    input  rs_dest, alloc_stall, dispatch_valid, dispatch_sel, consumed_bus
  );

  modport slave (
    input  mispredicted, issue_valid, issue_hold, busy_bus, ready_bus, fu_ready,
    output rs_dest, alloc_stall, dispatch_valid, dispatch_sel, consumed_bus
  );
endinterface

// File: rtl/rs_age_matrix.sv
// 4x4 relative-age register: r_age[i][j] = station i is older than station j.
// Reports which stations in a mask are older than every other masked station.
module rs_age_matrix
  import structs_pkg::*;
(
  input  logic       clk,
  input  logic       i_clr,
  input  logic       i_alloc,
  input  rs_idx_t    i_alloc_idx,
  input  rs_onehot_t i_mask,
  output rs_onehot_t o_oldest
);
  logic [N_RS-1:0][N_RS-1:0] r_age;

  // The newly allocated station becomes younger than everyone else.
  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_age <= '0;
    end else if (i_alloc) begin
      for (int i = 0; i < N_RS; i++) begin
        if (i == int'(i_alloc_idx)) r_age[i]              <= '0;
        else                        r_age[i][i_alloc_idx] <= 1'b1;
      end
    end
  end

  always_comb begin
    o_oldest = i_mask;
    for (int i = 0; i < N_RS; i++)
      for (int j = 0; j < N_RS; j++)
        if (i != j && i_mask[j] && !r_age[i][j]) o_oldest[i] = 1'b0;
  end
endmodule

// File: rtl/rs_dispatch_scheduler.sv
// Free-station allocation and ready-station dispatch for a 4-entry RS bank.
// Build option RS_SCHED_OLDEST_FIRST_EN: oldest ready station wins; otherwise lowest index.
module rs_dispatch_scheduler
  import structs_pkg::*;
(
  input logic                    clk,
  input logic                    reset,
  rs_dispatch_scheduler_if.slave bus
);
  disp_state_e r_state;
  rs_idx_t     r_sel;

  logic       w_flush;
  logic       w_stall;
  logic       w_alloc_fire;
  rs_idx_t    w_alloc_idx;
  rs_onehot_t w_free;
  rs_onehot_t w_held;
  rs_onehot_t w_cand;
  rs_idx_t    w_win;

  assign w_flush      = reset | bus.mispredicted;
  assign w_free       = ~bus.busy_bus;
  assign w_stall      = bus.issue_valid & (w_free == '0);
  assign w_alloc_idx  = lowest_idx(w_free);
  assign w_alloc_fire = bus.issue_valid & ~w_stall & ~bus.issue_hold & ~w_flush;

  assign bus.rs_dest     = (w_free == '0) ? RS_NONE : {1'b0, w_alloc_idx};
  assign bus.alloc_stall = w_stall;

  // The offered station stays busy until the handshake; keep it out of re-selection.
  assign w_held = (r_state == DISP_HOLD) ? idx2oh(r_sel) : '0;
  assign w_cand = bus.busy_bus & bus.ready_bus & ~w_held;

`ifdef RS_SCHED_OLDEST_FIRST_EN
  rs_onehot_t w_oldest;

  rs_age_matrix u_age (
    .clk         (clk),
    .i_clr       (w_flush),
    .i_alloc     (w_alloc_fire),
    .i_alloc_idx (w_alloc_idx),
    .i_mask      (w_cand),
    .o_oldest    (w_oldest)
  );

  assign w_win = lowest_idx(w_oldest);
`else
  logic w_unused_alloc;
  assign w_unused_alloc = w_alloc_fire;
  assign w_win          = lowest_idx(w_cand);
`endif

  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_state <= DISP_EMPTY;
      r_sel   <= '0;
    end else begin
      case (r_state)
        DISP_EMPTY: begin
          if (w_cand != '0) begin
            r_state <= DISP_HOLD;
            r_sel   <= w_win;
          end
        end
        DISP_HOLD: begin
          if (bus.fu_ready) begin
            if (w_cand != '0) r_sel   <= w_win;
            else              r_state <= DISP_EMPTY;
          end
        end
        default: r_state <= DISP_EMPTY;
      endcase
    end
  end

  assign bus.dispatch_valid = (r_state == DISP_HOLD);
  assign bus.dispatch_sel   = r_sel;
  assign bus.consumed_bus   = (r_state == DISP_HOLD && bus.fu_ready && !w_flush)
                              ? idx2oh(r_sel) : '0;
endmodule
